// File: rtl/accumulate_scheduler.sv
// -----------------------------------------------------------------------------
// accumulate_scheduler
//
// Shares a single accumulate unit between NUM_REQ embedding-bag requesters in
// the DLRM pooling stage. Whole bags are arbitrated round-robin. Each granted
// bag is sequenced CONFIG -> ACCUMULATE x len -> DISABLE. One pooled sum is
// returned per bag.
//
// The accumulate unit never clears its running total. The scheduler therefore
// snapshots the total right after CONFIG and returns (final - snapshot),
// computed modulo 2^64.
//
// Optional feature macro: ACC_SCHED_TIMEOUT_EN
//   When defined, a bag whose stream stays idle for TIMEOUT_CYCLES
//   consecutive cycles is abandoned. The partial sum is returned with
//   rsp_err set. When undefined, the stream waits indefinitely.
//
// Parameters
//   NUM_REQ         number of requesters (2..16)
//   LEN_W           bag-length width (<= 28)
//   TIMEOUT_CYCLES  consecutive idle cycles before a bag is abandoned
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high
//   req_valid        per-requester bag request
//   req_len          bag lengths, slice i belongs to requester i
//   req_ready        one-hot, single-cycle grant pulse
//   grant_id         owner of the current bag
//   busy             a bag is in progress
//   in_valid/in_data/in_ready   element beats from the granted requester
//   acc_instruction  {op[63:60], count[59:32], capacity[31:0]} to accumulator
//   acc_data         accumulator data input
//   acc_result       accumulator registered running total
//   acc_bp           accumulator backpressure
//   rsp_valid/rsp_ready         pooled-result handshake
//   rsp_id           requester that owns the result
//   rsp_data         pooled sum
//   rsp_err          bag was backpressured or abandoned
// -----------------------------------------------------------------------------
module accumulate_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  input  logic                         in_valid,
  input  logic [63:0]                  in_data,
  output logic                         in_ready,
  output logic [63:0]                  acc_instruction,
  output logic [63:0]                  acc_data,
  input  logic [63:0]                  acc_result,
  input  logic                         acc_bp,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [63:0]                  rsp_data,
  output logic                         rsp_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef ACC_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_CONFIG     = 4'h1;
  localparam logic [3:0] OP_ACCUMULATE = 4'h2;
  localparam logic [3:0] OP_DISABLE    = 4'h3;

  // The state register runs one cycle ahead of the bus activity it produces,
  // because every output is registered. For example, S_CFG is the grant
  // cycle, and the CONFIG word is launched at the end of that cycle.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_BASE   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DIS    = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  logic [2:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [LEN_W-1:0] remaining;
  logic             err;
  logic             base_pend;
  logic [TO_W-1:0]  idle_cnt;
  logic [63:0]      base_p0;

  logic [LEN_W-1:0] len_arr [NUM_REQ];
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;
  logic             beat_fire;
  logic             timeout_hit;

  // Wrap-around difference between the final total and the snapshot taken
  // after CONFIG.
  function automatic logic [63:0] pool_sum(input logic [63:0] total,
                                           input logic [63:0] snap);
    pool_sum = total - snap;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
  end

  // Round-robin search. The search starts at the requester just after the
  // last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign beat_fire   = in_valid && in_ready;
  assign timeout_hit = TIMEOUT_EN && !in_valid &&
                       (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rr_ptr          <= ID_W'(NUM_REQ - 1);
      remaining       <= '0;
      err             <= 1'b0;
      base_pend       <= 1'b0;
      idle_cnt        <= '0;
      req_ready       <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      in_ready        <= 1'b0;
      acc_instruction <= '0;
      acc_data        <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
    end else begin
      req_ready       <= '0;
      acc_instruction <= {OP_NOP, 60'd0};
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            req_ready <= NUM_REQ'(1) << gnt_idx;
            grant_id  <= gnt_idx;
            rr_ptr    <= gnt_idx;
            remaining <= len_arr[gnt_idx];
            busy      <= 1'b1;
            err       <= 1'b0;
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          // A zero-length bag never touches the accumulator.
          if (remaining == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else begin
            acc_instruction <= {OP_CONFIG, 28'(remaining), 32'(remaining)};
            state           <= S_BASE;
          end
        end
        S_BASE: begin
          in_ready  <= 1'b1;
          base_pend <= 1'b1;
          idle_cnt  <= '0;
          state     <= S_STREAM;
        end
        S_STREAM: begin
          base_pend <= 1'b0;
          // Backpressure only matters once accumulate traffic can exist.
          if (!base_pend && acc_bp) begin
            err <= 1'b1;
          end
          if (beat_fire) begin
            acc_instruction <= {OP_ACCUMULATE, 60'd0};
            acc_data        <= in_data;
            remaining       <= remaining - LEN_W'(1);
            idle_cnt        <= '0;
            if (remaining == LEN_W'(1)) begin
              in_ready <= 1'b0;
              state    <= S_DRAIN;
            end
          end else if (timeout_hit) begin
            in_ready <= 1'b0;
            err      <= 1'b1;
            state    <= S_DRAIN;
          end else if (!in_valid) begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        S_DRAIN: begin
          if (acc_bp) begin
            err <= 1'b1;
          end
          acc_instruction <= {OP_DISABLE, 60'd0};
          state           <= S_DIS;
        end
        S_DIS: begin
          // The last ACCUMULATE has landed in acc_result by this cycle.
          rsp_valid <= 1'b1;
          rsp_id    <= grant_id;
          rsp_data  <= pool_sum(acc_result, base_p0);
          rsp_err   <= err;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Snapshot of the running total. Taken in the first stream cycle, after
  // CONFIG has settled and before any ACCUMULATE can land.
  always_ff @(posedge clk) begin
    if (state == S_STREAM && base_pend) begin
      base_p0 <= acc_result;
    end
  end

endmodule

// File: tb/tb_accumulate_scheduler.sv
module tb_accumulate_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_len;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [63:0] acc_instruction;
  logic [63:0] acc_data;
  logic [63:0] acc_result = 64'd0;
  logic        acc_bp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] bv [0:7];

  accumulate_scheduler #(
    .NUM_REQ(4),
    .LEN_W(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_len(req_len),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .busy(busy),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .acc_instruction(acc_instruction),
    .acc_data(acc_data),
    .acc_result(acc_result),
    .acc_bp(acc_bp),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Accumulator model: registered total that only ACCUMULATE changes.
  always @(posedge clk) begin
    if (acc_instruction[63:60] == 4'h2) begin
      acc_result <= acc_result + acc_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int len);
    req_valid[id] = 1'b1;
    req_len[id*16 +: 16] = 16'(len);
  endtask

  task automatic grant_expect(input int id);
    int n;
    n = 0;
    while (n < 20) begin
      tick();
      if (|req_ready) break;
      n++;
    end
    chk("grant_onehot", 64'(req_ready), 64'(4'b0001 << id));
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("busy_on", 64'(busy), 64'd1);
  endtask

  // Runs from the grant cycle to the cycle where the response first appears.
  task automatic run_body(input int len, input logic [63:0] exp_data,
                          input logic exp_err, input int exp_id, input int bp_at);
    if (len == 0) begin
      tick();
      chk("z_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("z_rsp_data", rsp_data, 64'd0);
      chk("z_rsp_err", 64'(rsp_err), 64'd0);
      chk("z_rsp_id", 64'(rsp_id), 64'(exp_id));
      chk("z_no_instr", acc_instruction, 64'd0);
      chk("z_in_ready", 64'(in_ready), 64'd0);
    end else begin
      tick();
      chk("config", acc_instruction, {4'h1, 28'(len), 32'(len)});
      chk("in_ready_pre", 64'(in_ready), 64'd0);
      tick();
      chk("in_ready_on", 64'(in_ready), 64'd1);
      for (int i = 0; i < len; i++) begin
        in_valid = 1'b1;
        in_data  = bv[i];
        tick();
        chk("acc_op", 64'(acc_instruction[63:60]), 64'd2);
        chk("acc_data", acc_data, bv[i]);
        acc_bp = (bp_at == i + 1);
      end
      in_valid = 1'b0;
      chk("in_ready_off", 64'(in_ready), 64'd0);
      acc_bp = 1'b0;
      tick();
      chk("disable", acc_instruction, 64'h3000_0000_0000_0000);
      chk("rsp_early", 64'(rsp_valid), 64'd0);
      tick();
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(exp_id));
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    end
  endtask

  task automatic rsp_take(input int hold, input int exp_id,
                          input logic [63:0] exp_data, input logic exp_err);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id", 64'(rsp_id), 64'(exp_id));
      chk("hold_data", rsp_data, exp_data);
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = '0;
    req_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_bp    = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_instr", acc_instruction, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Round-robin between requesters 0 and 2, with a held response.
    set_req(0, 1);
    set_req(2, 1);
    bv[0] = 64'd4;
    grant_expect(0);
    run_body(1, 64'd4, 1'b0, 0, 0);
    rsp_take(5, 0, 64'd4, 1'b0);
    bv[0] = 64'd11;
    grant_expect(2);
    run_body(1, 64'd11, 1'b0, 2, 0);
    rsp_take(0, 2, 64'd11, 1'b0);
    bv[0] = 64'd3;
    grant_expect(0);
    req_valid = '0;
    run_body(1, 64'd3, 1'b0, 0, 0);
    rsp_take(0, 0, 64'd3, 1'b0);

    // Back-to-back bags from requester 1: the base snapshot removes history.
    set_req(1, 2);
    bv[0] = 64'd1; bv[1] = 64'd2;
    grant_expect(1);
    req_valid = '0;
    run_body(2, 64'd3, 1'b0, 1, 0);
    rsp_take(0, 1, 64'd3, 1'b0);
    set_req(1, 2);
    bv[0] = 64'd10; bv[1] = 64'd20;
    grant_expect(1);
    req_valid = '0;
    run_body(2, 64'd30, 1'b0, 1, 0);
    rsp_take(0, 1, 64'd30, 1'b0);

    // Zero-length bag.
    set_req(3, 0);
    grant_expect(3);
    req_valid = '0;
    run_body(0, 64'd0, 1'b0, 3, 0);
    rsp_take(0, 3, 64'd0, 1'b0);

    // Basic bag: 5 + 7 + 9.
    set_req(0, 3);
    bv[0] = 64'd5; bv[1] = 64'd7; bv[2] = 64'd9;
    grant_expect(0);
    req_valid = '0;
    run_body(3, 64'd21, 1'b0, 0, 0);
    rsp_take(0, 0, 64'd21, 1'b0);

    // Backpressure after the second ACCUMULATE.
    set_req(0, 4);
    bv[0] = 64'd1; bv[1] = 64'd2; bv[2] = 64'd3; bv[3] = 64'd4;
    grant_expect(0);
    req_valid = '0;
    run_body(4, 64'd10, 1'b1, 0, 2);
    rsp_take(0, 0, 64'd10, 1'b1);

    // Reset in the middle of a requester-1 bag.
    set_req(1, 3);
    grant_expect(1);
    req_valid = '0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 64'd8;
    tick();
    in_valid = 1'b0;
    chk("mid_acc_op", 64'(acc_instruction[63:60]), 64'd2);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_req_ready", 64'(req_ready), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_instr", acc_instruction, 64'd0);
    chk("mr_acc_data", acc_data, 64'd0);
    chk("mr_grant_id", 64'(grant_id), 64'd0);
    chk("mr_rsp_data", rsp_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
      chk("mr_no_instr", acc_instruction, 64'd0);
    end
    set_req(0, 1);
    set_req(2, 1);
    bv[0] = 64'd9;
    grant_expect(0);
    req_valid = '0;
    run_body(1, 64'd9, 1'b0, 0, 0);
    rsp_take(0, 0, 64'd9, 1'b0);

`ifdef ACC_SCHED_TIMEOUT_EN
    // Stream stalls after one beat and the bag is abandoned.
    set_req(0, 4);
    grant_expect(0);
    req_valid = '0;
    tick();
    chk("to_config", acc_instruction, 64'h1000_0004_0000_0004);
    tick();
    in_valid = 1'b1;
    in_data  = 64'd6;
    tick();
    in_valid = 1'b0;
    chk("to_acc_data", acc_data, 64'd6);
    n = 0;
    while (n < 40 && acc_instruction[63:60] != 4'h3) begin
      tick();
      n++;
    end
    chk("to_delay", 64'(n), 64'd9);
    tick();
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_data", rsp_data, 64'd6);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    rsp_take(0, 0, 64'd6, 1'b1);
`else
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
